display_scan: RTL and testbench

DISPLAY_SCAN -- requirements
Module: display_scan

---
 rtl/display_scan_if.sv | 24 ++
 rtl/display_scan.sv | 64 ++++++
 tb/tb_display_scan.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/display_scan_if.sv
// Bus between a display_scan scanner and whatever drives it: the data/control inputs and
// the registered digit-select, nibble and pulse outputs that go to the 7-segment decoder.
interface display_scan_if;
    logic [15:0] value;
    logic        load;
    logic        enable;
    logic        blank_lz;
    logic [3:0]  pick;
    logic [3:0]  numbers;
    logic [1:0]  digit_idx;
    logic        frame_tick;
    logic        load_ack;

    // load is a single-cycle request with no ready; load_ack pulses in the cycle the value reaches the display.
    modport master (
        output value, load, enable, blank_lz,
        input  pick, numbers, digit_idx, frame_tick, load_ack
    );

    modport slave (
        input  value, load, enable, blank_lz,
        output pick, numbers, digit_idx, frame_tick, load_ack
    );
endinterface

// File: rtl/display_scan.sv
// Four-digit multiplexed display scanner with double-buffered value, frame-aligned update
// and optional leading-zero blanking. All outputs are registered from next-state values.
module display_scan #(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input logic           clk,
    input logic           rst_n,
    display_scan_if.slave bus
);
    localparam logic [19:0] LAST = 20'(REFRESH_DIV - 1);

    logic [19:0] presc, presc_n;
    logic [1:0]  idx, idx_n;
    logic [15:0] disp, disp_n, pend;
    logic        pend_valid;
    logic        slot_end, frame_end, xfer, lit;
    logic [3:0]  nib;

    always_comb begin
        slot_end  = bus.enable && (presc == LAST);
        frame_end = slot_end && (idx == 2'd3);
        presc_n   = (!bus.enable || slot_end) ? 20'd0 : presc + 20'd1;
        idx_n     = !bus.enable ? 2'd0 : (slot_end ? idx + 2'd1 : idx);
        // A dark display has no frame to protect, so any pending value goes straight through.
        xfer      = bus.enable ? (frame_end && (bus.load || pend_valid))
                               : (bus.load || pend_valid);
        disp_n    = disp;
        if (xfer)
            disp_n = bus.load ? bus.value : pend;
        nib = disp_n[{idx_n, 2'b00} +: 4];
        lit = bus.enable &&
              ((idx_n == 2'd0) || !bus.blank_lz || ((disp_n >> {idx_n, 2'b00}) != 16'h0000));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc          <= 20'd0;
            idx            <= 2'd0;
            disp           <= 16'h0000;
            pend           <= 16'h0000;
            pend_valid     <= 1'b0;
            bus.pick       <= 4'b0000;
            bus.numbers    <= 4'h0;
            bus.digit_idx  <= 2'd0;
            bus.frame_tick <= 1'b0;
            bus.load_ack   <= 1'b0;
        end else begin
            presc <= presc_n;
            idx   <= idx_n;
            disp  <= disp_n;
            if (xfer) begin
                pend_valid <= 1'b0;
            end else if (bus.load) begin
                pend       <= bus.value;
                pend_valid <= 1'b1;
            end
            bus.pick       <= lit ? (4'b0001 << idx_n) : 4'b0000;
            bus.numbers    <= lit ? nib : 4'h0;
            bus.digit_idx  <= idx_n;
            bus.frame_tick <= frame_end;
            bus.load_ack   <= xfer;
        end
    end
endmodule

// File: tb/tb_display_scan.sv
// Bench for display_scan: per-cycle expected outputs come from an arithmetic model
// (edges since enable -> slot/digit) and are checked by an independent monitor.
module tb_display_scan;
    localparam int DIV = 4;
    localparam int W   = 12;

    logic clk;
    logic rst_n;
    display_scan_if bus ();

    display_scan #(.REFRESH_DIV(DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [W-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // reference model state
    logic [15:0] m_disp = 16'h0000;
    logic [15:0] m_pend = 16'h0000;
    logic        m_pv   = 1'b0;
    int          en_k   = 0;

    task automatic step(input logic r, input logic e, input logic l, input logic b,
                        input logic [15:0] v);
        logic        x, t;
        int          i;
        logic [15:0] nd;
        logic [3:0]  ep, en;
        rst_n        = r;
        bus.enable   = e;
        bus.load     = l;
        bus.blank_lz = b;
        bus.value    = v;
        ep = 4'b0000; en = 4'h0; i = 0; t = 1'b0; x = 1'b0;
        if (!r) begin
            m_disp = 16'h0000; m_pv = 1'b0; en_k = 0;
        end else if (!e) begin
            en_k = 0;
            x = l || m_pv;
            if (x) begin
                m_disp = l ? v : m_pend;
                m_pv   = 1'b0;
            end
        end else begin
            en_k++;
            t = (en_k % (4 * DIV)) == 0;
            i = (en_k / DIV) % 4;
            if (t && (l || m_pv)) begin
                x = 1'b1;
                m_disp = l ? v : m_pend;
                m_pv   = 1'b0;
            end else if (l) begin
                m_pend = v;
                m_pv   = 1'b1;
            end
            nd = m_disp >> (4 * i);
            if (i == 0 || !b || nd != 16'h0000) begin
                ep = 4'(1 << i);
                en = nd[3:0];
            end
        end
        exp_q.push_back({ep, en, 2'(i), t, x});
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input logic b);
        for (int k = 0; k < n; k++) step(1'b1, 1'b1, 1'b0, b, 16'h0000);
    endtask

    // scoreboard monitor
    initial begin
        logic [W-1:0] exp, got;
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                got = {bus.pick, bus.numbers, bus.digit_idx, bus.frame_tick, bus.load_ack};
                total++;
                if (got !== exp) begin
                    bad++;
                    $display("FAIL outputs cyc=%0d got pick=%b num=%h idx=%0d tick=%b ack=%b exp pick=%b num=%h idx=%0d tick=%b ack=%b",
                             cyc, got[11:8], got[7:4], got[3:2], got[1], got[0],
                             exp[11:8], exp[7:4], exp[3:2], exp[1], exp[0]);
                end
            end
        end
    end

    // stimulus
    initial begin
        // reset with a load and enable that must be discarded
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'hDEAD);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        // basic load and scan
        step(1'b1, 1'b1, 1'b1, 1'b0, 16'h1234);
        run(40, 1'b0);
        // latest-wins within a frame
        step(1'b1, 1'b1, 1'b1, 1'b0, 16'hAAAA);
        run(3, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 16'h5555);
        run(32, 1'b0);
        // leading-zero blanking
        step(1'b1, 1'b1, 1'b1, 1'b1, 16'h0070);
        run(32, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 16'h0000);
        run(32, 1'b1);
        run(8, 1'b0);
        // disable mid-slot at digit 2 with a pending value
        for (int k = 0; k < 64 && !(((en_k / DIV) % 4) == 2 && (en_k % DIV) == 1); k++)
            run(1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 16'hBEEF);
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        run(20, 1'b0);
        // reset mid-frame with a pending value
        step(1'b1, 1'b1, 1'b1, 1'b0, 16'h9876);
        run(2, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        run(52, 1'b0);
        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            step(($urandom_range(0, 299) != 0),
                 ($urandom_range(0, 49) != 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom));
        end
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got %0d left exp 0 left", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
